// File: rtl/zebra_stripe_scanner.sv
// Scans NUM_COLS vertical pixel columns of a BRAM-held image and counts
// foreground stripes per column to decide whether a zebra crossing is present.
module zebra_stripe_scanner #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int PIXEL_BITS   = 2,
    parameter int FG_THRESHOLD = 1,
    parameter int NUM_COLS     = 8,
    parameter int COL_START    = 40,
    parameter int COL_STEP     = 80,
    parameter int MIN_RUN      = 4,
    parameter int MAX_RUN      = 120,
    parameter int MIN_STRIPES  = 3,
    parameter int MIN_AGREE    = 5
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      crossing_detected,
    output logic [7:0]                                stripe_count,
    output logic [$clog2(NUM_COLS+1)-1:0]             agree_count,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]   bram_addr,
    input  logic [PIXEL_BITS-1:0]                     bram_data
);

    localparam int ADDR_W  = $clog2(IMG_WIDTH*IMG_HEIGHT);
    localparam int AGREE_W = $clog2(NUM_COLS+1);
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int RUN_W   = $clog2(MAX_RUN+2);

    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_HEIGHT-1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(NUM_COLS-1);
    localparam logic [ADDR_W-1:0] ROW_INC  = ADDR_W'(IMG_WIDTH);
    localparam logic [ADDR_W-1:0] COL_INC  = ADDR_W'(COL_STEP);
    localparam logic [ADDR_W-1:0] COL_X0   = ADDR_W'(COL_START);
    localparam logic [RUN_W-1:0]  RUN_SAT  = RUN_W'(MAX_RUN+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_COL_END,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_col_base;
    logic [ROW_W-1:0]     r_row;
    logic [COL_W-1:0]     r_col;
    logic                 r_vld_p1;
    logic [RUN_W-1:0]     r_run;
    logic [7:0]           r_cnt;
    logic [AGREE_W-1:0]   r_agree;
    logic [7:0]           r_max;
    logic [7:0]           r_stripe_count;
    logic [AGREE_W-1:0]   r_agree_count;
    logic                 r_crossing;

    logic                 w_fg;
    logic                 w_last_col;
    logic [7:0]           w_col_final;
    logic                 w_col_agrees;
    logic [AGREE_W-1:0]   w_agree_nxt;
    logic [7:0]           w_max_nxt;
    logic [ADDR_W-1:0]    w_next_base;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (v == RUN_SAT) ? v : v + RUN_W'(1);
    endfunction

    function automatic logic run_ok(input logic [RUN_W-1:0] len);
        return (len >= RUN_W'(MIN_RUN)) && (len <= RUN_W'(MAX_RUN));
    endfunction

    assign w_fg         = (bram_data >= PIXEL_BITS'(FG_THRESHOLD));
    assign w_last_col   = (r_col == COL_LAST);
    // A run still open after the last row is closed here, at column end.
    assign w_col_final  = run_ok(r_run) ? sat_inc8(r_cnt) : r_cnt;
    assign w_col_agrees = (w_col_final >= 8'(MIN_STRIPES));
    assign w_agree_nxt  = r_agree + AGREE_W'(w_col_agrees);
    assign w_max_nxt    = (w_col_final > r_max) ? w_col_final : r_max;
    assign w_next_base  = r_col_base + COL_INC;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (r_row == ROW_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy        = 1'b1;
                w_state_nxt = S_COL_END;
            end
            S_COL_END: begin
                busy        = 1'b1;
                w_state_nxt = w_last_col ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr         <= '0;
            r_col_base     <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_vld_p1       <= 1'b0;
            r_run          <= '0;
            r_cnt          <= '0;
            r_agree        <= '0;
            r_max          <= '0;
            r_stripe_count <= '0;
            r_agree_count  <= '0;
            r_crossing     <= 1'b0;
        end else begin
            // p0 -> p1: address issued in SCAN; its data arrives next cycle
            r_vld_p1 <= (r_state == S_SCAN);

            // p1: evaluate the pixel returned for the previous address
            if (r_vld_p1) begin
                if (w_fg) begin
                    r_run <= sat_inc_run(r_run);
                end else begin
                    if (run_ok(r_run)) r_cnt <= sat_inc8(r_cnt);
                    r_run <= '0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= COL_X0;
                        r_col_base <= COL_X0;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_run      <= '0;
                        r_cnt      <= '0;
                        r_agree    <= '0;
                        r_max      <= '0;
                    end
                end
                S_SCAN: begin
                    if (r_row != ROW_LAST) begin
                        r_row  <= r_row + ROW_W'(1);
                        r_addr <= r_addr + ROW_INC;
                    end
                end
                S_COL_END: begin
                    r_run   <= '0;
                    r_cnt   <= '0;
                    r_agree <= w_agree_nxt;
                    r_max   <= w_max_nxt;
                    if (w_last_col) begin
                        r_stripe_count <= w_max_nxt;
                        r_agree_count  <= w_agree_nxt;
                        r_crossing     <= (w_agree_nxt >= AGREE_W'(MIN_AGREE));
                    end else begin
                        r_col      <= r_col + COL_W'(1);
                        r_col_base <= w_next_base;
                        r_addr     <= w_next_base;
                        r_row      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bram_addr         = r_addr;
    assign stripe_count      = r_stripe_count;
    assign agree_count       = r_agree_count;
    assign crossing_detected = r_crossing;

endmodule

// File: tb/tb_zebra_stripe_scanner.sv
// Self-checking bench for zebra_stripe_scanner: directed band images plus random
// images, all compared against a run-segment reference model of the image.
module tb_zebra_stripe_scanner;

    localparam int W      = 640;
    localparam int H      = 480;
    localparam int NPIX   = W * H;
    localparam int NCOLS  = 8;
    localparam int CX0    = 40;
    localparam int CSTEP  = 80;
    localparam int TH     = 1;
    localparam int MINR   = 4;
    localparam int MAXR   = 120;
    localparam int MINS   = 3;
    localparam int MINA   = 5;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int AG_W   = $clog2(NCOLS+1);
    localparam int LAT    = NCOLS * (H + 2) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              crossing_detected;
    logic [7:0]        stripe_count;
    logic [AG_W-1:0]   agree_count;
    logic [ADDR_W-1:0] bram_addr;
    logic [1:0]        bram_data;

    logic [1:0] img [0:NPIX-1];

    int n_tests = 0;
    int n_fail  = 0;
    int prev_sc = 0;
    int prev_ag = 0;
    int prev_cr = 0;

    always #5 clk = ~clk;

    always @(posedge clk) bram_data <= img[bram_addr];

    zebra_stripe_scanner dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .crossing_detected (crossing_detected),
        .stripe_count      (stripe_count),
        .agree_count       (agree_count),
        .bram_addr         (bram_addr),
        .bram_data         (bram_data)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_fg(input int x, input int y);
        return img[y*W + x] >= 2'(TH);
    endfunction

    // Reference: find each maximal foreground segment in a column, keep the
    // ones whose length lies in [MINR, MAXR].
    task automatic model(output int sc, output int ag, output int cr);
        int x, cnt, st, len;
        sc = 0;
        ag = 0;
        for (int k = 0; k < NCOLS; k++) begin
            x   = CX0 + k * CSTEP;
            cnt = 0;
            st  = 0;
            for (int y = 0; y < H; y++) begin
                if (is_fg(x, y) && (y == 0 || !is_fg(x, y-1))) st = y;
                if (is_fg(x, y) && (y == H-1 || !is_fg(x, y+1))) begin
                    len = y - st + 1;
                    if (len >= MINR && len <= MAXR) cnt++;
                end
            end
            if (cnt > 255) cnt = 255;
            if (cnt >= MINS) ag++;
            if (cnt > sc) sc = cnt;
        end
        cr = (ag >= MINA) ? 1 : 0;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < NPIX; i++) img[i] = 2'(v);
    endtask

    task automatic fill_bands(input int wh, input int bl, input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y*W + x] = ((y % (wh + bl)) < wh) ? 2'(v) : 2'd0;
    endtask

    task automatic set_col(input int k, input int y0, input int y1, input int v);
        for (int y = y0; y <= y1; y++) img[y*W + CX0 + k*CSTEP] = 2'(v);
    endtask

    task automatic fill_random();
        int y, len;
        bit fg;
        for (int i = 0; i < NPIX; i++) img[i] = 2'($urandom_range(0, 3));
        for (int k = 0; k < NCOLS; k++) begin
            y  = 0;
            fg = 1'($urandom_range(0, 1));
            while (y < H) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 140);
                for (int i = 0; i < len && y + i < H; i++)
                    img[(y+i)*W + CX0 + k*CSTEP] = fg ? 2'($urandom_range(1, 3)) : 2'd0;
                y  = y + len;
                fg = !fg;
            end
        end
    endtask

    task automatic run_scan(input string tag, input bit pulses);
        int sc, ag, cr, n, busy_bad;
        bit seen;
        model(sc, ag, cr);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        n        = 1;
        busy_bad = 0;
        seen     = 1'b0;
        while (n < LAT + 40) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (n == 100) begin
                check_val({tag, "/held_sc"}, 32'(stripe_count), prev_sc);
                check_val({tag, "/held_ag"}, 32'(agree_count), prev_ag);
                check_val({tag, "/held_cr"}, 32'(crossing_detected), prev_cr);
            end
            start = pulses && (n % 500 == 7);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check_val({tag, "/done_seen"}, 32'(seen), 1);
        check_val({tag, "/latency"}, n, LAT);
        check_val({tag, "/busy_during"}, busy_bad, 0);
        check_val({tag, "/busy_at_done"}, 32'(busy), 0);
        check_val({tag, "/stripe_count"}, 32'(stripe_count), sc);
        check_val({tag, "/agree_count"}, 32'(agree_count), ag);
        check_val({tag, "/crossing"}, 32'(crossing_detected), cr);
        // start raised during the DONE cycle must be ignored
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, "/done_pulse"}, 32'(done), 0);
        @(posedge clk);
        #1;
        check_val({tag, "/idle_after"}, 32'(busy), 0);
        check_val({tag, "/results_held"}, 32'(stripe_count), sc);
        prev_sc = sc;
        prev_ag = ag;
        prev_cr = cr;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill_const(0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst/busy", 32'(busy), 0);
        check_val("rst/done", 32'(done), 0);
        check_val("rst/addr", 32'(bram_addr), 0);
        check_val("rst/sc", 32'(stripe_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("idle/busy", 32'(busy), 0);
        check_val("idle/addr", 32'(bram_addr), 0);

        run_scan("zero", 1'b0);
        check_val("zero/sc_const", 32'(stripe_count), 0);
        check_val("zero/cr_const", 32'(crossing_detected), 0);

        fill_bands(20, 20, 1);
        run_scan("bands20", 1'b0);
        check_val("bands20/sc_const", 32'(stripe_count), 12);
        check_val("bands20/ag_const", 32'(agree_count), 8);
        check_val("bands20/cr_const", 32'(crossing_detected), 1);

        fill_bands(3, 3, 1);
        run_scan("bands3", 1'b0);
        check_val("bands3/sc_const", 32'(stripe_count), 0);
        check_val("bands3/cr_const", 32'(crossing_detected), 0);

        fill_bands(130, 130, 1);
        run_scan("bands130", 1'b0);
        check_val("bands130/sc_const", 32'(stripe_count), 0);
        check_val("bands130/cr_const", 32'(crossing_detected), 0);

        fill_const(0);
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < H / 40; b++) set_col(k, b*40, b*40 + 19, 1);
        set_col(0, 470, 479, 1);
        run_scan("edge", 1'b0);
        check_val("edge/sc_const", 32'(stripe_count), 13);
        check_val("edge/ag_const", 32'(agree_count), 4);
        check_val("edge/cr_const", 32'(crossing_detected), 0);

        fill_bands(20, 20, 2);
        run_scan("val2_pulses", 1'b1);
        check_val("val2/sc_const", 32'(stripe_count), 12);
        check_val("val2/ag_const", 32'(agree_count), 8);

        // mid-scan asynchronous reset
        fill_bands(20, 20, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (999) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("midrst/busy", 32'(busy), 0);
        check_val("midrst/done", 32'(done), 0);
        check_val("midrst/addr", 32'(bram_addr), 0);
        check_val("midrst/sc", 32'(stripe_count), 0);
        check_val("midrst/ag", 32'(agree_count), 0);
        check_val("midrst/cr", 32'(crossing_detected), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_val("midrst/quiet_busy", 32'(busy), 0);
        check_val("midrst/quiet_addr", 32'(bram_addr), 0);
        prev_sc = 0;
        prev_ag = 0;
        prev_cr = 0;
        run_scan("rescan", 1'b0);
        check_val("rescan/sc_const", 32'(stripe_count), 12);
        check_val("rescan/ag_const", 32'(agree_count), 8);
        check_val("rescan/cr_const", 32'(crossing_detected), 1);

        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_scan($sformatf("rand%0d", t), t == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
